// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared core types for the issue/operand-fetch slice.
//               XLEN, register-index width, register-index type and the
//               pass-through bundle carried by the issue output register.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int PKG_CTRL_W = 16;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Fields of an issued instruction that travel unchanged to execute.
   typedef struct packed {
      reg_addr_t             rd;
      logic                  rd_we;
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       imm;
      logic [PKG_CTRL_W-1:0] ctrl;
   } issue_pkt_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : One pending-write bit per architectural register.
//               Ports:
//                 clk, rst_n               clock / async active-low reset
//                 set_en, set_addr         new writer issued to set_addr
//                 clr_en, clr_addr         write-back retired clr_addr
//                 kill_en, kill_addr       flushed writer drops its bit
//                 rs1/rs2/rd_addr          lookup indices
//                 rs1/rs2/rd_pending       pending bits with this cycle's
//                                          write-back already removed
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
   import core_pkg::*;
#(
   parameter int REGISTER_COUNT = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      set_en,
   input  reg_addr_t set_addr,
   input  logic      clr_en,
   input  reg_addr_t clr_addr,
   input  logic      kill_en,
   input  reg_addr_t kill_addr,
   input  reg_addr_t rs1_addr,
   input  reg_addr_t rs2_addr,
   input  reg_addr_t rd_addr,
   output logic      rs1_pending,
   output logic      rs2_pending,
   output logic      rd_pending
);

   logic [REGISTER_COUNT-1:0] r_pending;
   logic [REGISTER_COUNT-1:0] w_clr;
   logic [REGISTER_COUNT-1:0] w_set;
   logic [REGISTER_COUNT-1:0] w_kill;
   logic [REGISTER_COUNT-1:0] w_pend_eff;

   generate
      for (genvar g = 0; g < REGISTER_COUNT; g++) begin : g_reg
         if (g == 0) begin : g_zero
            // x0 is never written, so it can never be pending.
            assign w_clr[g]  = 1'b0;
            assign w_set[g]  = 1'b0;
            assign w_kill[g] = 1'b0;
            always_ff @(posedge clk or negedge rst_n) begin
               r_pending[g] <= 1'b0;
            end
         end else begin : g_live
            assign w_clr[g]  = clr_en  && (clr_addr  == reg_addr_t'(g));
            assign w_set[g]  = set_en  && (set_addr  == reg_addr_t'(g));
            assign w_kill[g] = kill_en && (kill_addr == reg_addr_t'(g));
            // A new writer wins over a same-cycle write-back of the old one.
            // Kill never coincides with set (no issue during flush).
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  r_pending[g] <= 1'b0;
               end else begin
                  r_pending[g] <= ((r_pending[g] & ~w_clr[g]) | w_set[g]) & ~w_kill[g];
               end
            end
         end
         assign w_pend_eff[g] = r_pending[g] & ~w_clr[g];
      end
   endgenerate

   assign rs1_pending = w_pend_eff[rs1_addr];
   assign rs2_pending = w_pend_eff[rs2_addr];
   assign rd_pending  = w_pend_eff[rd_addr];

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Issue / operand-fetch stage between decode and execute.
//               Drives register-file read addresses, captures rs1/rs2 with a
//               bypass from the same-cycle write-back, stalls on RAW/WAW
//               hazards tracked by reg_scoreboard, and presents the result in
//               a valid/ready output register.
//               Ports:
//                 in_*          decoded instruction + valid/ready handshake
//                 rf_address*   combinational register-file read addresses
//                 rf_read_data* combinational register-file read data
//                 wb_*          write-back strobe / index / data
//                 flush         kill the instruction held at the output
//                 out_*         operands and pass-through fields to execute
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch
   import core_pkg::*;
#(
   parameter int REGISTER_COUNT = 32,
   parameter int CTRL_W         = PKG_CTRL_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [4:0]        in_rd,
   input  logic              in_rd_we,
   input  logic [31:0]       in_pc,
   input  logic [31:0]       in_imm,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic [4:0]        rf_address1,
   output logic [4:0]        rf_address2,
   input  logic [31:0]       rf_read_data1,
   input  logic [31:0]       rf_read_data2,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [31:0]       wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_rs1_data,
   output logic [31:0]       out_rs2_data,
   output logic [4:0]        out_rd,
   output logic              out_rd_we,
   output logic [31:0]       out_pc,
   output logic [31:0]       out_imm,
   output logic [CTRL_W-1:0] out_ctrl
);

   localparam logic [XLEN-1:0] c_zero = '0;
   localparam reg_addr_t       c_x0   = '0;

   logic        r_out_valid;
   logic [31:0] r_rs1_data;
   logic [31:0] r_rs2_data;
   issue_pkt_t  r_pkt;

   logic        w_rs1_pending;
   logic        w_rs2_pending;
   logic        w_rd_pending;
   logic        w_hazard;
   logic        w_slot_free;
   logic        w_issue;
   logic        w_set_en;
   logic        w_kill_en;
   logic        w_bypass1;
   logic        w_bypass2;
   logic [31:0] w_rs1_data;
   logic [31:0] w_rs2_data;

   assign rf_address1 = in_rs1;
   assign rf_address2 = in_rs2;

   reg_scoreboard #(
      .REGISTER_COUNT (REGISTER_COUNT)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .set_en      (w_set_en),
      .set_addr    (in_rd),
      .clr_en      (wb_en),
      .clr_addr    (wb_addr),
      .kill_en     (w_kill_en),
      .kill_addr   (r_pkt.rd),
      .rs1_addr    (in_rs1),
      .rs2_addr    (in_rs2),
      .rd_addr     (in_rd),
      .rs1_pending (w_rs1_pending),
      .rs2_pending (w_rs2_pending),
      .rd_pending  (w_rd_pending)
   );

   // Pending lookups already exclude this cycle's write-back, so a
   // producer retiring now does not stall its consumer.
   assign w_hazard = ((in_rs1 != c_x0) && w_rs1_pending) ||
                     ((in_rs2 != c_x0) && w_rs2_pending) ||
                     (in_rd_we && (in_rd != c_x0) && w_rd_pending);

   assign w_slot_free = !r_out_valid || out_ready;
   // rst_n term keeps in_ready low while reset is asserted.
   assign in_ready    = rst_n && !w_hazard && w_slot_free && !flush;
   assign w_issue     = in_valid && in_ready;

   assign w_set_en  = w_issue && in_rd_we && (in_rd != c_x0);
   assign w_kill_en = flush && r_out_valid && r_pkt.rd_we;

   // x0 never bypasses, even if a write-back names it.
   assign w_bypass1 = wb_en && (wb_addr != c_x0) && (wb_addr == in_rs1);
   assign w_bypass2 = wb_en && (wb_addr != c_x0) && (wb_addr == in_rs2);

   assign w_rs1_data = (in_rs1 == c_x0) ? c_zero :
                       w_bypass1        ? wb_data : rf_read_data1;
   assign w_rs2_data = (in_rs2 == c_x0) ? c_zero :
                       w_bypass2        ? wb_data : rf_read_data2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_pkt       <= '0;
      end else begin
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_issue) begin
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_issue) begin
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_pkt.rd    <= in_rd;
            r_pkt.rd_we <= in_rd_we;
            r_pkt.pc    <= in_pc;
            r_pkt.imm   <= in_imm;
            r_pkt.ctrl  <= in_ctrl;
         end
      end
   end

   assign out_valid    = r_out_valid;
   assign out_rs1_data = r_rs1_data;
   assign out_rs2_data = r_rs2_data;
   assign out_rd       = r_pkt.rd;
   assign out_rd_we    = r_pkt.rd_we;
   assign out_pc       = r_pkt.pc;
   assign out_imm      = r_pkt.imm;
   assign out_ctrl     = r_pkt.ctrl;

endmodule : operand_fetch
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_fetch
// Description : Self-checking bench for operand_fetch. Issued instructions
//               push their expected operands/fields to a queue; a monitor
//               pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [4:0]  in_rd;
   logic        in_rd_we;
   logic [31:0] in_pc;
   logic [31:0] in_imm;
   logic [15:0] in_ctrl;
   logic [4:0]  rf_address1;
   logic [4:0]  rf_address2;
   logic [31:0] rf_read_data1;
   logic [31:0] rf_read_data2;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_rs1_data;
   logic [31:0] out_rs2_data;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic [31:0] out_pc;
   logic [31:0] out_imm;
   logic [15:0] out_ctrl;

   typedef struct {
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        we;
      logic [15:0] ctrl;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   operand_fetch #(
      .REGISTER_COUNT (32),
      .CTRL_W         (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_rs1        (in_rs1),
      .in_rs2        (in_rs2),
      .in_rd         (in_rd),
      .in_rd_we      (in_rd_we),
      .in_pc         (in_pc),
      .in_imm        (in_imm),
      .in_ctrl       (in_ctrl),
      .rf_address1   (rf_address1),
      .rf_address2   (rf_address2),
      .rf_read_data1 (rf_read_data1),
      .rf_read_data2 (rf_read_data2),
      .wb_en         (wb_en),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .flush         (flush),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_rs1_data  (out_rs1_data),
      .out_rs2_data  (out_rs2_data),
      .out_rd        (out_rd),
      .out_rd_we     (out_rd_we),
      .out_pc        (out_pc),
      .out_imm       (out_imm),
      .out_ctrl      (out_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at posedge+2, so they are stable at the negedge where
   // the monitor decides whether a transfer happens on the next posedge.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && flush !== 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected out_pc=%h with empty expected queue", out_pc);
         end else begin
            mon_e = sb.pop_front();
            if (out_rs1_data !== mon_e.rs1 || out_rs2_data !== mon_e.rs2 ||
                out_pc !== mon_e.pc || out_imm !== mon_e.imm || out_rd !== mon_e.rd ||
                out_rd_we !== mon_e.we || out_ctrl !== mon_e.ctrl) begin
               errors++;
               $display("FAIL xfer got rs1=%h rs2=%h pc=%h imm=%h rd=%0d we=%b ctrl=%h expected rs1=%h rs2=%h pc=%h imm=%h rd=%0d we=%b ctrl=%h",
                        out_rs1_data, out_rs2_data, out_pc, out_imm, out_rd, out_rd_we, out_ctrl,
                        mon_e.rs1, mon_e.rs2, mon_e.pc, mon_e.imm, mon_e.rd, mon_e.we, mon_e.ctrl);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic present(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic [31:0] pc);
      in_valid = v;
      in_rs1   = rs1;
      in_rs2   = rs2;
      in_rd    = rd;
      in_rd_we = we;
      in_pc    = pc;
      in_imm   = pc ^ 32'h5A5A_0F0F;
      in_ctrl  = pc[15:0] ^ 16'h00FF;
   endtask

   task automatic push_exp(input logic [31:0] rs1d, input logic [31:0] rs2d);
      sb.push_back('{rs1: rs1d, rs2: rs2d, pc: in_pc, imm: in_imm, rd: in_rd, we: in_rd_we, ctrl: in_ctrl});
   endtask

   task automatic idle();
      in_valid = 1'b0;
      wb_en    = 1'b0;
      wb_addr  = 5'd0;
      flush    = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
      end
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b0;
      present(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'h10);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_issue in_ready=%b expected 1", in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      in_valid = 1'b0;
      #1;
      // Async reset mid-cycle: everything clears without a clock edge.
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_rd_we !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_async out_valid=%b out_pc=%h out_rd_we=%b in_ready=%b expected 0 0 0 0",
                  out_valid, out_pc, out_rd_we, in_ready);
      end
      sb.delete();
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;
      // x3 was pending before reset; it must be free now.
      present(1'b0, 5'd3, 5'd0, 5'd3, 1'b1, 32'h14);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_pending_cleared in_ready=%b expected 1", in_ready);
      end
      idle();
      cyc();
   endtask

   task automatic test_raw();
      out_ready = 1'b1;
      rf_read_data1 = 32'd0;
      rf_read_data2 = 32'd0;
      present(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 32'h100);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL raw_producer in_ready=%b expected 1", in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      present(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 32'h104);
      rf_read_data1 = 32'hAAAA_0000;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL raw_stall[%0d] in_ready=%b expected 0", i, in_ready);
         end
         cyc();
      end
      wb_en = 1'b1;
      wb_addr = 5'd5;
      wb_data = 32'h1234;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL raw_release in_ready=%b expected 1", in_ready);
      end
      push_exp(32'h1234, 32'd0);
      cyc();
      idle();
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_rs1_data !== 32'h1234) begin
         errors++;
         $display("FAIL raw_bypass out_valid=%b out_rs1_data=%h expected 1 00001234", out_valid, out_rs1_data);
      end
      wb_en = 1'b1;
      wb_addr = 5'd6;
      wb_data = 32'h66;
      cyc();
      idle();
      cyc();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      rf_read_data1 = 32'h11;
      rf_read_data2 = 32'h22;
      present(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 32'h200);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_first in_ready=%b expected 1", in_ready);
      end
      push_exp(32'h11, 32'h22);
      cyc();
      present(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 32'h204);
      rf_read_data1 = 32'h33;
      rf_read_data2 = 32'h44;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200 || out_rs1_data !== 32'h11) begin
            errors++;
            $display("FAIL bp_hold[%0d] in_ready=%b out_valid=%b out_pc=%h out_rs1=%h expected 0 1 00000200 00000011",
                     i, in_ready, out_valid, out_pc, out_rs1_data);
         end
         cyc();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release in_ready=%b expected 1", in_ready);
      end
      push_exp(32'h33, 32'h44);
      cyc();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h204) begin
         errors++;
         $display("FAIL bp_no_bubble out_valid=%b out_pc=%h expected 1 00000204", out_valid, out_pc);
      end
      cyc();
   endtask

   task automatic test_x0();
      out_ready = 1'b1;
      rf_read_data1 = 32'hDEAD;
      rf_read_data2 = 32'hCAFE;
      wb_en = 1'b1;
      wb_addr = 5'd0;
      wb_data = 32'hBEEF;
      present(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h300);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_first in_ready=%b expected 1", in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      present(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'h304);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL x0_never_pending in_ready=%b expected 1", in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      idle();
      cyc();
   endtask

   task automatic test_waw_flush();
      out_ready = 1'b0;
      rf_read_data1 = 32'd0;
      rf_read_data2 = 32'd0;
      present(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h400);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL waw_first in_ready=%b expected 1", in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      present(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 32'h404);
      out_ready = 1'b1;
      #1;
      // Slot would be free (out_ready=1) but x7 still has a writer in flight.
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL waw_stall in_ready=%b expected 0", in_ready);
      end
      out_ready = 1'b0;
      flush = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL flush_blocks_issue in_ready=%b expected 0", in_ready);
      end
      cyc();
      flush = 1'b0;
      void'(sb.pop_back());
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_kill out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h404) begin
         errors++;
         $display("FAIL waw_second_issued out_valid=%b out_pc=%h expected 1 00000404", out_valid, out_pc);
      end
      cyc();
      wb_en = 1'b1;
      wb_addr = 5'd7;
      wb_data = 32'h7;
      cyc();
      idle();
      cyc();
   endtask

   task automatic test_set_clear();
      out_ready = 1'b1;
      present(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h500);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL setclr_first in_ready=%b expected 1", in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      present(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h504);
      wb_en = 1'b1;
      wb_addr = 5'd9;
      wb_data = 32'h77;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL setclr_same_cycle in_ready=%b expected 1", in_ready);
      end
      push_exp(32'd0, 32'd0);
      cyc();
      wb_en = 1'b0;
      rf_read_data1 = 32'hBAD1;
      rf_read_data2 = 32'hBAD2;
      present(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 32'h508);
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL setclr_pending[%0d] in_ready=%b expected 0", i, in_ready);
         end
         cyc();
      end
      wb_en = 1'b1;
      wb_addr = 5'd9;
      wb_data = 32'h99;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL setclr_release in_ready=%b expected 1", in_ready);
      end
      push_exp(32'h99, 32'h99);
      cyc();
      idle();
      cyc();
      cyc();
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      in_valid = 1'b0;
      in_rs1 = 5'd0;
      in_rs2 = 5'd0;
      in_rd = 5'd0;
      in_rd_we = 1'b0;
      in_pc = 32'd0;
      in_imm = 32'd0;
      in_ctrl = 16'd0;
      rf_read_data1 = 32'd0;
      rf_read_data2 = 32'd0;
      wb_en = 1'b0;
      wb_addr = 5'd0;
      wb_data = 32'd0;
      flush = 1'b0;
      test_reset();
      test_raw();
      test_backpressure();
      test_x0();
      test_waw_flush();
      test_set_clear();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_empty pending_expected=%0d expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_operand_fetch
`default_nettype wire
